// File: rtl/lab5_mcore_mem_req_arbiter.sv
// lab5_mcore_mem_req_arbiter: round-robin sharing of one memory port with in-order response routing.
// Defining LAB5_MCORE_MEM_ARB_STATS_EN adds per-requester grant counters on stats_grants.
module lab5_mcore_mem_req_arbiter #(
    parameter int p_num_reqs     = 4,
    parameter int p_max_inflight = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [p_num_reqs*77-1:0] reqs_msg,
    input  logic [p_num_reqs-1:0]    reqs_val,
    output logic [p_num_reqs-1:0]    reqs_rdy,
    output logic [p_num_reqs*47-1:0] resps_msg,
    output logic [p_num_reqs-1:0]    resps_val,
    input  logic [p_num_reqs-1:0]    resps_rdy,
    output logic [76:0]              memreq_msg,
    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    input  logic [46:0]              memresp_msg,
    input  logic                     memresp_val,
`ifdef LAB5_MCORE_MEM_ARB_STATS_EN
    output logic [p_num_reqs*32-1:0] stats_grants,
`endif
    output logic                     memresp_rdy
);
    localparam int IW = $clog2(p_num_reqs);
    localparam int DW = $clog2(p_max_inflight);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_tags [p_max_inflight];
    logic [DW-1:0] r_head, r_tail;
    logic [DW:0]   r_count;
    logic [IW-1:0] w_win, w_idx, w_head_tag;
    logic          w_found, w_full, w_empty, w_enq, w_deq;
    always_comb begin
        w_win = r_ptr;
        w_idx = '0;
        w_found = 1'b0;
        for (int k = 0; k < p_num_reqs; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % p_num_reqs);
            if (!w_found && reqs_val[w_idx]) begin
                w_win = w_idx;
                w_found = 1'b1;
            end
        end
    end
    assign w_full     = r_count == (DW+1)'(p_max_inflight);
    assign w_empty    = r_count == '0;
    assign w_head_tag = r_tags[r_head];
    assign memreq_msg = reqs_msg[int'(w_win)*77 +: 77];
    assign memreq_val = w_found && !w_full;
    assign w_enq      = memreq_val && memreq_rdy;
    assign resps_msg  = {p_num_reqs{memresp_msg}};
    assign memresp_rdy = !w_empty && resps_rdy[w_head_tag];
    assign w_deq      = memresp_val && memresp_rdy;
    always_comb begin
        reqs_rdy = '0;
        resps_val = '0;
        reqs_rdy[w_win] = w_found && memreq_rdy && !w_full;
        resps_val[w_head_tag] = memresp_val && !w_empty;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_ptr          <= (int'(w_win) == p_num_reqs - 1) ? '0 : w_win + 1'b1;
                r_tags[r_tail] <= w_win;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_deq)
                r_head <= r_head + 1'b1;
            r_count <= r_count + (DW+1)'(w_enq) - (DW+1)'(w_deq);
        end
    end
`ifdef LAB5_MCORE_MEM_ARB_STATS_EN
    logic [31:0] r_stats [p_num_reqs];
    always_ff @(posedge clk)
        for (int i = 0; i < p_num_reqs; i++)
            if (reset)
                r_stats[i] <= '0;
            else if (w_enq && int'(w_win) == i)
                r_stats[i] <= r_stats[i] + 32'd1;
    for (genvar g = 0; g < p_num_reqs; g++)
        assign stats_grants[g*32 +: 32] = r_stats[g];
`endif
    // A response with no outstanding tag has nowhere to go; memory must never do this.
    assert property (@(posedge clk) disable iff (reset) !(memresp_val && w_empty));
endmodule

// File: tb/tb_lab5_mcore_mem_req_arbiter.sv
// tb_lab5_mcore_mem_req_arbiter: directed bench, in-flight destinations kept in a scoreboard queue.
module tb_lab5_mcore_mem_req_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [307:0] reqs_msg;
    logic [3:0]   reqs_val, reqs_rdy, resps_val, resps_rdy;
    logic [187:0] resps_msg;
    logic [76:0]  memreq_msg;
    logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [46:0]  memresp_msg;
`ifdef LAB5_MCORE_MEM_ARB_STATS_EN
    logic [127:0] stats_grants;
`endif
    int nvec = 0;
    int nfail = 0;
    int tq[$];
    int ng[4];

    lab5_mcore_mem_req_arbiter #(.p_num_reqs(4), .p_max_inflight(4)) dut (
        .clk(clk), .reset(reset),
        .reqs_msg(reqs_msg), .reqs_val(reqs_val), .reqs_rdy(reqs_rdy),
        .resps_msg(resps_msg), .resps_val(resps_val), .resps_rdy(resps_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val),
`ifdef LAB5_MCORE_MEM_ARB_STATS_EN
        .stats_grants(stats_grants),
`endif
        .memresp_rdy(memresp_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [76:0] rmsg(int i);
        return {8'(i), 32'hC0DE_0000 + 32'(i), 32'(i * 7 + 3), 5'(i + 1)};
    endfunction

    function automatic logic [46:0] rsp(int n);
        return {15'(n + 100), 32'hBEEF_0000 + 32'(n)};
    endfunction

    task automatic chk(string tag, logic [76:0] obs, logic [76:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic grant(int w);
        chk("memreq_val", 77'(memreq_val), 77'(1));
        chk("reqs_rdy", 77'(reqs_rdy), memreq_rdy ? 77'(1 << w) : 77'(0));
        chk("memreq_msg", memreq_msg, rmsg(w));
        if (memreq_rdy) begin
            tq.push_back(w);
            ng[w]++;
        end
    endtask

    task automatic resp(logic [46:0] m, logic fire);
        int h = tq[0];
        chk("resps_val", 77'(resps_val), 77'(1 << h));
        chk("resps_msg", 77'(resps_msg[h*47 +: 47]), 77'(m));
        chk("memresp_rdy", 77'(memresp_rdy), 77'(fire));
        if (fire)
            void'(tq.pop_front());
    endtask

    task automatic do_reset();
        reqs_val = '0;
        memresp_val = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tq.delete();
        for (int i = 0; i < 4; i++)
            ng[i] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        for (int i = 0; i < 4; i++)
            reqs_msg[i*77 +: 77] = rmsg(i);
        memreq_rdy = 1'b0;
        resps_rdy = '0;
        memresp_msg = '0;
        do_reset();
        @(negedge clk);
        #1;
        chk("rst_reqs_rdy", 77'(reqs_rdy), 77'(0));
        chk("rst_memreq_val", 77'(memreq_val), 77'(0));
        chk("rst_resps_val", 77'(resps_val), 77'(0));
        chk("rst_memresp_rdy", 77'(memresp_rdy), 77'(0));
        resps_rdy = 4'hF;
        memreq_rdy = 1'b1;
        #1;
        chk("idle_memresp_rdy", 77'(memresp_rdy), 77'(0));
        chk("idle_memreq_val", 77'(memreq_val), 77'(0));
        @(negedge clk);
        // all four valid: grants rotate 0,1,2,3,0 with one response per cycle
        reqs_val = 4'hF;
        for (int k = 0; k < 5; k++) begin
            memresp_val = (k != 0);
            memresp_msg = rsp(k);
            #1;
            if (k != 0)
                resp(rsp(k), 1'b1);
            grant(k % 4);
            @(negedge clk);
        end
        reqs_val = '0;
        memresp_msg = rsp(5);
        #1;
        resp(rsp(5), 1'b1);
        @(negedge clk);
        do_reset();
        // only req 2 valid while memory stalls; pointer must hold
        reqs_val = 4'b0100;
        memreq_rdy = 1'b0;
        repeat (3) begin
            #1;
            grant(2);
            @(negedge clk);
        end
        memreq_rdy = 1'b1;
        #1;
        grant(2);
        @(negedge clk);
        reqs_val = 4'hF;
        memreq_rdy = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = rsp(6);
        #1;
        resp(rsp(6), 1'b1);
        grant(3);
        @(negedge clk);
        memresp_val = 1'b0;
        #1;
        grant(3);
        @(negedge clk);
        memreq_rdy = 1'b1;
        #1;
        grant(3);
        @(negedge clk);
        reqs_val = '0;
        memresp_val = 1'b1;
        memresp_msg = rsp(7);
        #1;
        resp(rsp(7), 1'b1);
        @(negedge clk);
        memresp_val = 1'b0;
        // req 1 then req 3; response A stalls on resps_rdy[1]
        reqs_val = 4'b0010;
        #1;
        grant(1);
        @(negedge clk);
        reqs_val = 4'b1000;
        #1;
        grant(3);
        @(negedge clk);
        reqs_val = '0;
        memresp_val = 1'b1;
        memresp_msg = rsp(8);
        resps_rdy = 4'b1101;
        repeat (2) begin
            #1;
            resp(rsp(8), 1'b0);
            chk("resps_msg_bcast", 77'(resps_msg[46:0]), 77'(rsp(8)));
            @(negedge clk);
        end
        resps_rdy = 4'hF;
        #1;
        resp(rsp(8), 1'b1);
        @(negedge clk);
        memresp_msg = rsp(9);
        #1;
        resp(rsp(9), 1'b1);
        @(negedge clk);
        memresp_val = 1'b0;
        // fill the tag FIFO; fifth request waits for a dequeue
        reqs_val = 4'b0001;
        repeat (4) begin
            #1;
            grant(0);
            @(negedge clk);
        end
        memresp_val = 1'b1;
        memresp_msg = rsp(10);
        #1;
        chk("full_reqs_rdy", 77'(reqs_rdy), 77'(0));
        chk("full_memreq_val", 77'(memreq_val), 77'(0));
        resp(rsp(10), 1'b1);
        @(negedge clk);
        memresp_val = 1'b0;
        #1;
        grant(0);
        @(negedge clk);
        reqs_val = '0;
        memresp_val = 1'b1;
        memresp_msg = rsp(11);
        #1;
        resp(rsp(11), 1'b1);
        @(negedge clk);
        // reset with tags still in flight
        do_reset();
        #1;
        chk("mid_rst_memresp_rdy", 77'(memresp_rdy), 77'(0));
        chk("mid_rst_memreq_val", 77'(memreq_val), 77'(0));
        chk("mid_rst_resps_val", 77'(resps_val), 77'(0));
        reqs_val = 4'hF;
        #1;
        grant(0);
        @(negedge clk);
        reqs_val = 4'b0100;
        #1;
        grant(2);
        @(negedge clk);
        reqs_val = '0;
        memresp_val = 1'b1;
        memresp_msg = rsp(12);
        #1;
        resp(rsp(12), 1'b1);
        @(negedge clk);
        memresp_msg = rsp(13);
        #1;
        resp(rsp(13), 1'b1);
        @(negedge clk);
        memresp_val = 1'b0;
`ifdef LAB5_MCORE_MEM_ARB_STATS_EN
        #1;
        for (int i = 0; i < 4; i++)
            chk("stats_grants", 77'(stats_grants[i*32 +: 32]), 77'(ng[i]));
`endif
        chk("tq_drained", 77'(tq.size()), 77'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
